// File: rtl/bus_pkg.sv
// Shared types for the sram-like bus arbiter: owner tag, request bundle
// and the largest owner-FIFO depth the arbiter supports.
package bus_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        uncached;
    } sram_req_t;

    localparam int MAX_DEPTH = 8;

endpackage

// File: rtl/owner_fifo.sv
// In-order owner tracker: one entry per accepted request, head names the
// master whose response the downstream slave will return next.
module owner_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  owner_e din,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    owner_e           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master sram-like bus arbiter: data has priority, inst is protected from
// starvation, a stalled grant is held until accepted, responses routed in order.
module sram_like_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic        inst_uncached,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic        data_uncached,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic        bus_uncached,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    localparam int DEPTH = (MAX_OUTSTANDING > MAX_DEPTH) ? MAX_DEPTH : MAX_OUTSTANDING;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    sram_req_t        inst_in;
    sram_req_t        data_in;
    sram_req_t        sel;
    sram_req_t        bus_out;
    owner_e           gnt;
    owner_e           owner;
    owner_e           head;
    logic             gnt_valid;
    logic             locked;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [SC_W-1:0]  starve_cnt;

    assign inst_in = '{req: inst_req, wr: inst_wr, size: inst_size, addr: inst_addr,
                       wdata: inst_wdata, uncached: inst_uncached};
    assign data_in = '{req: data_req, wr: data_wr, size: data_size, addr: data_addr,
                       wdata: data_wdata, uncached: data_uncached};

    always_comb begin
        gnt_valid = 1'b0;
        gnt       = OWN_DATA;
        if (locked) begin
            gnt_valid = 1'b1;
            gnt       = owner;
        end else if (inst_req && starve_cnt == SC_W'(STARVE_LIMIT)) begin
            gnt_valid = 1'b1;
            gnt       = OWN_INST;
        end else if (data_req) begin
            gnt_valid = 1'b1;
            gnt       = OWN_DATA;
        end else if (inst_req) begin
            gnt_valid = 1'b1;
            gnt       = OWN_INST;
        end
        sel     = (gnt == OWN_DATA) ? data_in : inst_in;
        bus_out = (gnt_valid && sel.req && !fifo_full) ? sel : '0;
    end

    assign bus_req      = bus_out.req;
    assign bus_wr       = bus_out.wr;
    assign bus_size     = bus_out.size;
    assign bus_addr     = bus_out.addr;
    assign bus_wdata    = bus_out.wdata;
    assign bus_uncached = bus_out.uncached;

    assign push = bus_req && bus_addr_ok;
    assign pop  = bus_data_ok && !fifo_empty;

    assign inst_addr_ok = push && (gnt == OWN_INST);
    assign data_addr_ok = push && (gnt == OWN_DATA);
    // The FIFO head reflects only earlier pushes, so a same-cycle accept never answers itself.
    assign inst_data_ok = pop && (head == OWN_INST);
    assign data_data_ok = pop && (head == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign busy         = !fifo_empty || locked;

    owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (gnt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked     <= 1'b0;
            owner      <= OWN_DATA;
            starve_cnt <= '0;
        end else begin
            if (push) begin
                locked <= 1'b0;
            end else if (bus_req) begin
                locked <= 1'b1;
                owner  <= gnt;
            end
            if (!inst_req || (push && gnt == OWN_INST)) begin
                starve_cnt <= '0;
            end else if (push && gnt == OWN_DATA && starve_cnt != SC_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: conflict, lock, full FIFO,
// push/pop overlap, starvation and mid-transaction reset.
module tb_sram_like_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr, inst_uncached;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr, data_uncached;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr, bus_uncached;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_uncached(inst_uncached),
        .inst_size(inst_size), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_uncached(data_uncached),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_uncached(bus_uncached),
        .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_uncached = 0; inst_size = 2'd2;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_uncached = 0; data_size = 2'd2;
        data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_req"},  bus_req, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_size"}, bus_size, 0);
        chk({tag, "_addr_ok"},  {inst_addr_ok, data_addr_ok}, 0);
        chk({tag, "_data_ok"},  {inst_data_ok, data_data_ok}, 0);
        chk({tag, "_rdata"},    inst_rdata | data_rdata, 0);
        chk({tag, "_busy"},     busy, 0);
    endtask

    initial begin
        idle();
        rst = 0;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1;

        // Same-cycle conflict: data wins, inst follows, responses in order.
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wdata = 32'h55;
        bus_addr_ok = 1;
        settle();
        chk("conf_bus_addr0", bus_addr, 32'h2000);
        chk("conf_bus_wr0", bus_wr, 1);
        chk("conf_data_aok", data_addr_ok, 1);
        chk("conf_inst_aok0", inst_addr_ok, 0);
        tick();
        data_req = 0; data_wr = 0; data_wdata = 0;
        settle();
        chk("conf_bus_addr1", bus_addr, 32'h1000);
        chk("conf_inst_aok1", inst_addr_ok, 1);
        tick();
        inst_req = 0; bus_addr_ok = 0;
        bus_data_ok = 1; bus_rdata = 32'hAAAA;
        settle();
        chk("conf_busy", busy, 1);
        chk("conf_rsp0_data", data_data_ok, 1);
        chk("conf_rsp0_inst", inst_data_ok, 0);
        chk("conf_rsp0_rdata", data_rdata, 32'hAAAA);
        tick();
        bus_rdata = 32'hBBBB;
        settle();
        chk("conf_rsp1_inst", inst_data_ok, 1);
        chk("conf_rsp1_data", data_data_ok, 0);
        chk("conf_rsp1_rdata", inst_rdata, 32'hBBBB);
        tick();
        bus_data_ok = 0; bus_rdata = 0;
        settle();
        chk("conf_idle_busy", busy, 0);

        // Lock: stalled inst grant is held while data requests arrive.
        inst_req = 1; inst_addr = 32'h3000;
        settle();
        chk("lock_a_bus_req", bus_req, 1);
        chk("lock_a_addr", bus_addr, 32'h3000);
        chk("lock_a_inst_aok", inst_addr_ok, 0);
        tick();
        data_req = 1; data_addr = 32'h4000;
        settle();
        chk("lock_b_addr", bus_addr, 32'h3000);
        chk("lock_b_busy", busy, 1);
        tick();
        settle();
        chk("lock_c_addr", bus_addr, 32'h3000);
        tick();
        bus_addr_ok = 1;
        settle();
        chk("lock_d_addr", bus_addr, 32'h3000);
        chk("lock_d_aok", {inst_addr_ok, data_addr_ok}, 2'b10);
        tick();
        inst_req = 0;
        settle();
        chk("lock_e_addr", bus_addr, 32'h4000);
        chk("lock_e_aok", {inst_addr_ok, data_addr_ok}, 2'b01);
        tick();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        settle();
        chk("lock_rsp0", {inst_data_ok, data_data_ok}, 2'b10);
        tick();
        settle();
        chk("lock_rsp1", {inst_data_ok, data_data_ok}, 2'b01);
        tick();
        bus_data_ok = 0;

        // Full FIFO: four accepts, fifth blocked even with a pop pending.
        data_req = 1; data_addr = 32'h5000; bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("full_aok%0d", i), data_addr_ok, 1);
            tick();
        end
        settle();
        chk("full_bus_req", bus_req, 0);
        chk("full_bus_addr", bus_addr, 0);
        chk("full_data_aok", data_addr_ok, 0);
        bus_data_ok = 1;
        settle();
        chk("full_pop_blocks", bus_req, 0);
        chk("full_pop_rsp", data_data_ok, 1);
        tick();
        bus_data_ok = 0;
        settle();
        chk("full_reopen", bus_req, 1);

        // Push and pop together at count 3: count unchanged, order kept.
        data_req = 0; inst_req = 1; inst_addr = 32'h6000; bus_data_ok = 1;
        settle();
        chk("pp_inst_aok", inst_addr_ok, 1);
        chk("pp_rsp", {inst_data_ok, data_data_ok}, 2'b01);
        tick();
        inst_req = 0; data_req = 1; bus_data_ok = 0;
        settle();
        chk("pp_fill_aok", data_addr_ok, 1);
        tick();
        settle();
        chk("pp_now_full", bus_req, 0);
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("pp_drain%0d", i), {inst_data_ok, data_data_ok},
                (i == 2) ? 2'b10 : 2'b01);
            tick();
        end
        bus_data_ok = 0;
        settle();
        chk("pp_empty_busy", busy, 0);

        // Starvation: eight data grants, then inst, then data again.
        data_req = 1; data_addr = 32'h7000; inst_req = 1; inst_addr = 32'h8000;
        bus_addr_ok = 1; bus_data_ok = 1;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("starve_d%0d", i), bus_addr, 32'h7000);
            if (i == 0) chk("starve_orphan", {inst_data_ok, data_data_ok}, 2'b00);
            tick();
        end
        settle();
        chk("starve_inst_addr", bus_addr, 32'h8000);
        chk("starve_inst_aok", {inst_addr_ok, data_addr_ok}, 2'b10);
        tick();
        settle();
        chk("starve_clear_addr", bus_addr, 32'h7000);
        chk("starve_inst_rsp", {inst_data_ok, data_data_ok}, 2'b10);
        tick();
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
        settle();
        chk("starve_last_rsp", {inst_data_ok, data_data_ok}, 2'b01);
        tick();
        bus_data_ok = 0;
        settle();
        chk("starve_busy", busy, 0);

        // Reset while two transactions are outstanding.
        data_req = 1; data_addr = 32'h9000; bus_addr_ok = 1;
        tick();
        tick();
        idle();
        settle();
        chk("rst_pre_busy", busy, 1);
        rst = 0;
        settle();
        chk_all_zero("rst_mid");
        tick();
        rst = 1;
        bus_data_ok = 1; bus_rdata = 32'h1234;
        settle();
        chk("rst_orphan", {inst_data_ok, data_data_ok}, 2'b00);
        chk("rst_orphan_rdata", data_rdata, 32'h1234);
        chk("rst_orphan_busy", busy, 0);
        tick();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
